aurora_rx_frame_buffer: RTL and testbench



---
 rtl/aurora_rx_pkg.sv | 19 +
 rtl/aurora_rx_frame_ram.sv | 25 ++
 rtl/aurora_rx_frame_buffer.sv | 198 +++++++++++++++++++
 tb/tb_aurora_rx_frame_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_rx_pkg.sv
// Shared types for the Aurora RX frame buffer: beat record and ingress state encoding.
package aurora_rx_pkg;

    localparam int RX_DATA_W = 128;
    localparam int RX_KEEP_W = RX_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic                 tlast;
        logic [RX_KEEP_W-1:0] tkeep;
        logic [RX_DATA_W-1:0] tdata;
    } rx_beat_t;

endpackage

// File: rtl/aurora_rx_frame_ram.sv
// Simple dual-port beat store: one write port, one read port with a registered output.
module aurora_rx_frame_ram #(
    parameter int ADDR_W = 9,
    parameter int WIDTH  = 145
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/aurora_rx_frame_buffer.sv
// Store-and-forward RX frame buffer behind one Aurora 64B/66B channel.
// Optional sequence-number checking is built when RX_SEQ_CHECK_EN is defined.
module aurora_rx_frame_buffer
    import aurora_rx_pkg::*;
#(
    parameter int DATA_W    = RX_DATA_W,
    parameter int KEEP_W    = RX_KEEP_W,
    parameter int ADDR_W    = 9,
    parameter int MAX_BEATS = 256
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              channel_up,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic [KEEP_W-1:0] rx_tkeep,
    input  logic              rx_tlast,
    input  logic              rx_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [31:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic [ADDR_W:0]   fill_level
`ifdef RX_SEQ_CHECK_EN
    ,
    output logic [15:0]       seq_err_cnt
`endif
);

    localparam int               PTR_W = ADDR_W + 1;
    localparam int               CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1 << ADDR_W);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    rx_state_e        r_state;
    logic [PTR_W-1:0] r_wr_ptr, r_wr_commit, r_rd_ptr, r_rd_addr;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [31:0]      r_frame_cnt;
    logic [15:0]      r_drop_cnt;

    logic [PTR_W-1:0] w_used;
    logic             w_beat, w_space, w_accept, w_commit;

    assign w_used   = r_wr_ptr - r_rd_ptr;
    assign w_space  = (w_used < DEPTH) && (r_beat_cnt != MAX_CNT);
    assign w_beat   = channel_up && rx_tvalid && (r_state != ST_DISCARD);
    assign w_accept = w_beat && w_space;
    assign w_commit = w_accept && rx_tlast;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else if (!channel_up) begin
            // Channel loss cuts any frame in progress; committed data is untouched.
            if (r_state == ST_RECV) begin
                r_wr_ptr   <= r_wr_commit;
                r_beat_cnt <= '0;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_state <= ST_IDLE;
        end else if (rx_tvalid) begin
            case (r_state)
                ST_IDLE, ST_RECV: begin
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                        if (rx_tlast) begin
                            r_wr_commit <= r_wr_ptr + PTR_W'(1);
                            r_beat_cnt  <= '0;
                            r_state     <= ST_IDLE;
                            if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 32'd1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                            r_state    <= ST_RECV;
                        end
                    end else begin
                        r_wr_ptr   <= r_wr_commit;
                        r_beat_cnt <= '0;
                        r_state    <= rx_tlast ? ST_IDLE : ST_DISCARD;
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                end
                ST_DISCARD: if (rx_tlast) r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Egress: prefetch from the committed region into a two-deep skid so a
    // stalled sink holds its beat while the RAM read latency stays hidden.
    rx_beat_t   w_wdata, w_rdata;
    rx_beat_t   r_skid0, r_skid1;
    logic [1:0] r_skid_cnt;
    logic       r_inflight;
    logic       w_pop, w_rd;
    logic [2:0] w_occ;

    assign w_wdata = '{tlast: rx_tlast, tkeep: rx_tkeep, tdata: rx_tdata};
    assign w_pop   = (r_skid_cnt != 2'd0) && m_tready;
    assign w_occ   = {1'b0, r_skid_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_rd    = (r_rd_addr != r_wr_commit) && (w_occ < 3'd2);

    aurora_rx_frame_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  ($bits(rx_beat_t))
    ) u_ram (
        .clk     (user_clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_rd),
        .i_raddr (r_rd_addr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_rd_ptr   <= '0;
            r_rd_addr  <= '0;
            r_inflight <= 1'b0;
            r_skid_cnt <= 2'd0;
            r_skid0    <= '0;
            r_skid1    <= '0;
        end else begin
            r_inflight <= w_rd;
            if (w_rd)  r_rd_addr <= r_rd_addr + PTR_W'(1);
            if (w_pop) r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            case ({w_pop, r_inflight})
                2'b11: begin
                    if (r_skid_cnt == 2'd2) begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= w_rdata;
                    end else begin
                        r_skid0 <= w_rdata;
                    end
                end
                2'b10: begin
                    r_skid0    <= r_skid1;
                    r_skid_cnt <= r_skid_cnt - 2'd1;
                end
                2'b01: begin
                    if (r_skid_cnt == 2'd0) r_skid0 <= w_rdata;
                    else                    r_skid1 <= w_rdata;
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign m_tdata    = r_skid0.tdata;
    assign m_tkeep    = r_skid0.tkeep;
    assign m_tlast    = r_skid0.tlast;
    assign m_tvalid   = (r_skid_cnt != 2'd0);
    assign frame_cnt  = r_frame_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign fill_level = w_used;

`ifdef RX_SEQ_CHECK_EN
    logic [15:0] r_seq_cap, r_seq_exp, r_seq_err;
    logic        r_seq_seeded, r_chan_up_q;
    logic [15:0] w_seq_val;
    logic        w_rise;

    assign w_rise    = channel_up && !r_chan_up_q;
    assign w_seq_val = (r_beat_cnt == '0) ? rx_tdata[15:0] : r_seq_cap;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_seq_cap    <= '0;
            r_seq_exp    <= '0;
            r_seq_err    <= '0;
            r_seq_seeded <= 1'b0;
            r_chan_up_q  <= 1'b0;
        end else begin
            r_chan_up_q <= channel_up;
            if (w_accept && r_beat_cnt == '0) r_seq_cap <= rx_tdata[15:0];
            if (w_commit) begin
                r_seq_exp    <= w_seq_val + 16'd1;
                r_seq_seeded <= 1'b1;
                if (r_seq_seeded && !w_rise && w_seq_val != r_seq_exp && r_seq_err != '1)
                    r_seq_err <= r_seq_err + 16'd1;
            end else if (w_rise) begin
                r_seq_seeded <= 1'b0;
            end
        end
    end

    assign seq_err_cnt = r_seq_err;
`endif

endmodule

// File: tb/tb_aurora_rx_frame_buffer.sv
// Self-checking bench for aurora_rx_frame_buffer (covers RX_SEQ_CHECK_EN when defined).
module tb_aurora_rx_frame_buffer;
    import aurora_rx_pkg::*;

    logic         user_clk = 1'b0;
    logic         user_rst_n = 1'b0;
    logic         channel_up = 1'b0;
    logic [127:0] rx_tdata = '0;
    logic [15:0]  rx_tkeep = '0;
    logic         rx_tlast = 1'b0;
    logic         rx_tvalid = 1'b0;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tlast, m_tvalid;
    logic         m_tready = 1'b0;
    logic [31:0]  frame_cnt;
    logic [15:0]  drop_cnt;
    logic [9:0]   fill_level;
`ifdef RX_SEQ_CHECK_EN
    logic [15:0]  seq_err_cnt;
`endif

    aurora_rx_frame_buffer dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .channel_up (channel_up),
        .rx_tdata   (rx_tdata),
        .rx_tkeep   (rx_tkeep),
        .rx_tlast   (rx_tlast),
        .rx_tvalid  (rx_tvalid),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt),
`ifdef RX_SEQ_CHECK_EN
        .seq_err_cnt(seq_err_cnt),
`endif
        .fill_level (fill_level)
    );

    always #5 user_clk = ~user_clk;

    int       n_tests = 0;
    int       n_fail  = 0;
    int       n_out   = 0;
    int       ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    rx_beat_t exp_q[$];

    typedef struct {
        int len;
        int frame_inc;
        int drop_inc;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge user_clk) begin
        #1;
        case (ready_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Egress scoreboard and stall-stability monitor, sampled mid-cycle.
    rx_beat_t stall_beat;
    bit       stalled = 0;
    always @(negedge user_clk) begin
        rx_beat_t cur, e;
        cur = '{tlast: m_tlast, tkeep: m_tkeep, tdata: m_tdata};
        if (user_rst_n) begin
            if (stalled) begin
                check("stall_valid", {159'b0, m_tvalid}, 160'd1);
                check("stall_data", {15'b0, cur}, {15'b0, stall_beat});
            end
            if (m_tvalid && m_tready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", {15'b0, cur}, {15'b0, e});
                end
            end
            stalled    = m_tvalid && !m_tready;
            stall_beat = cur;
        end else begin
            stalled = 0;
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic send_frame(input int len, input logic [15:0] seq, input bit commit, input bit has_last);
        rx_beat_t q[$];
        rx_beat_t b;
        for (int i = 0; i < len; i++) begin
            b.tdata = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) b.tdata[15:0] = seq;
            b.tkeep = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            b.tlast = has_last && (i == len - 1);
            q.push_back(b);
            if (b.tlast && commit) foreach (q[k]) exp_q.push_back(q[k]);
            rx_tdata  = b.tdata;
            rx_tkeep  = b.tkeep;
            rx_tlast  = b.tlast;
            rx_tvalid = 1'b1;
            tick();
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || m_tvalid) && g < 5000) begin
            tick();
            g++;
        end
        n_tests++;
        if (g >= 5000) begin
            n_fail++;
            $display("FAIL %s: drain timeout, %0d beats still expected", name, exp_q.size());
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_frames = 0;
        int exp_drops  = 0;
        int out0;

        vecs[0] = '{1,   1, 0};
        vecs[1] = '{2,   1, 0};
        vecs[2] = '{4,   1, 0};
        vecs[3] = '{255, 1, 0};
        vecs[4] = '{256, 1, 0};
        vecs[5] = '{257, 0, 1};
        vecs[6] = '{300, 0, 1};
        vecs[7] = '{2,   1, 0};
        vecs[8] = '{3,   1, 0};

        repeat (3) tick();
        check("rst_tvalid", {159'b0, m_tvalid}, 160'd0);
        check("rst_tdata", {32'b0, m_tdata}, 160'd0);
        check("rst_frame_cnt", {128'b0, frame_cnt}, 160'd0);
        check("rst_drop_cnt", {144'b0, drop_cnt}, 160'd0);
        check("rst_fill", {150'b0, fill_level}, 160'd0);
        user_rst_n = 1'b1;
        channel_up = 1'b1;
        ready_mode = 1;
        repeat (2) tick();

        // Latency: tlast at edge N, valid only after edge N+2.
        send_frame(4, 16'h0, 1, 1);
        check("lat_n0", {159'b0, m_tvalid}, 160'd0);
        tick();
        check("lat_n1", {159'b0, m_tvalid}, 160'd0);
        tick();
        check("lat_n2", {159'b0, m_tvalid}, 160'd1);
        drain("lat");
        exp_frames = 1;
        check("lat_frame_cnt", {128'b0, frame_cnt}, 160'(exp_frames));
        check("lat_drop_cnt", {144'b0, drop_cnt}, 160'(exp_drops));

        foreach (vecs[i]) begin
            send_frame(vecs[i].len, 16'(i), vecs[i].frame_inc == 1, 1);
            drain("vec");
            exp_frames += vecs[i].frame_inc;
            exp_drops  += vecs[i].drop_inc;
            check("vec_frame_cnt", {128'b0, frame_cnt}, 160'(exp_frames));
            check("vec_drop_cnt", {144'b0, drop_cnt}, 160'(exp_drops));
            check("vec_fill", {150'b0, fill_level}, 160'd0);
        end

        // Overflow: fill all 512 entries with a stalled sink, third frame drops.
        ready_mode = 0;
        repeat (2) tick();
        send_frame(256, 16'h10, 1, 1);
        send_frame(256, 16'h11, 1, 1);
        send_frame(10, 16'h12, 0, 1);
        tick();
        exp_frames += 2;
        exp_drops  += 1;
        check("full_drop_cnt", {144'b0, drop_cnt}, 160'(exp_drops));
        check("full_fill", {150'b0, fill_level}, 160'd512);
        check("full_frame_cnt", {128'b0, frame_cnt}, 160'(exp_frames));
        out0 = n_out;
        ready_mode = 1;
        drain("full");
        check("full_beats_out", 160'(n_out - out0), 160'd512);
        send_frame(3, 16'h13, 1, 1);
        drain("after_full");
        exp_frames += 1;
        check("after_full_frame_cnt", {128'b0, frame_cnt}, 160'(exp_frames));

        // Channel loss mid-frame rewinds to the committed boundary.
        ready_mode = 0;
        repeat (2) tick();
        send_frame(3, 16'h20, 1, 1);
        exp_frames += 1;
        check("cu_fill_pre", {150'b0, fill_level}, 160'd3);
        send_frame(5, 16'h21, 0, 0);
        check("cu_fill_mid", {150'b0, fill_level}, 160'd8);
        channel_up = 1'b0;
        tick();
        exp_drops += 1;
        check("cu_fill_rewind", {150'b0, fill_level}, 160'd3);
        check("cu_drop_cnt", {144'b0, drop_cnt}, 160'(exp_drops));
        channel_up = 1'b1;
        ready_mode = 1;
        drain("cu");
        check("cu_fill_end", {150'b0, fill_level}, 160'd0);
        check("cu_frame_cnt", {128'b0, frame_cnt}, 160'(exp_frames));

        // Random frames against a random-ready sink.
        ready_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            int len = $urandom_range(1, 8);
            int g = 0;
            while (fill_level > 10'd400 && g < 2000) begin
                tick();
                g++;
            end
            send_frame(len, 16'($urandom), 1, 1);
            repeat (len + $urandom_range(1, 3)) tick();
        end
        exp_frames += 1000;
        ready_mode = 1;
        drain("rand");
        check("rand_frame_cnt", {128'b0, frame_cnt}, 160'(exp_frames));
        check("rand_drop_cnt", {144'b0, drop_cnt}, 160'(exp_drops));

`ifdef RX_SEQ_CHECK_EN
        user_rst_n = 1'b0;
        repeat (2) tick();
        user_rst_n = 1'b1;
        tick();
        check("seq_rst", {144'b0, seq_err_cnt}, 160'd0);
        send_frame(2, 16'd0, 1, 1);
        send_frame(2, 16'd1, 1, 1);
        send_frame(2, 16'd2, 1, 1);
        send_frame(2, 16'd4, 1, 1);
        send_frame(2, 16'd5, 1, 1);
        drain("seq_a");
        check("seq_gap", {144'b0, seq_err_cnt}, 160'd1);
        channel_up = 1'b0;
        tick();
        channel_up = 1'b1;
        tick();
        send_frame(2, 16'hFFFF, 1, 1);
        send_frame(2, 16'h0000, 1, 1);
        send_frame(2, 16'h0001, 1, 1);
        drain("seq_b");
        check("seq_wrap", {144'b0, seq_err_cnt}, 160'd1);
        check("seq_frame_cnt", {128'b0, frame_cnt}, 160'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
